// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester 16x4 RAM arbiter.
// Owner encoding, burst counter width and the saturating burst increment live here.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned NUM_REQ    = 2;
    localparam int unsigned BURST_W    = 4;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_R0   = 2'b01;
    localparam logic [1:0] OWN_R1   = 2'b10;

    function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] cnt,
                                                     input logic [BURST_W-1:0] max_cnt);
        return (cnt >= max_cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/ram16x4.sv
// Single-port RAM: synchronous write, asynchronous read, contents not reset.
module ram16x4 #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram16x4_arbiter.sv
// Round-robin arbiter sharing one ram16x4 between two requesters, with locked bursts
// bounded by MAX_BURST and a one-cycle registered read response per requester.
module ram16x4_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1
);

    localparam logic [BURST_W-1:0] MaxCnt = BURST_W'(MAX_BURST);

    logic [NUM_REQ-1:0] gnt;
    logic               forced;
    logic               prio_q, prio_d;
    logic [1:0]         owner_q, owner_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata, ram_rdata;
    logic               rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Owner keeps the port below the burst limit, or at the limit while the other side is idle;
    // at the limit with the other side waiting, the other side is forced in.
    always_comb begin
        gnt    = '0;
        forced = 1'b0;
        if (owner_q == OWN_R0 && req0 && (burst_cnt_q < MaxCnt || !req1)) begin
            gnt[0] = 1'b1;
        end else if (owner_q == OWN_R1 && req1 && (burst_cnt_q < MaxCnt || !req0)) begin
            gnt[1] = 1'b1;
        end else if (owner_q == OWN_R0 && req0) begin
            gnt[1] = 1'b1;
            forced = 1'b1;
        end else if (owner_q == OWN_R1 && req1) begin
            gnt[0] = 1'b1;
            forced = 1'b1;
        end else if (req0 && req1) begin
            gnt[0] = !prio_q;
            gnt[1] = prio_q;
        end else begin
            gnt[0] = req0;
            gnt[1] = req1;
        end
    end

    // Without a grant the owner (if any) has dropped its request, so ownership always clears.
    always_comb begin
        prio_d      = prio_q;
        owner_d     = OWN_NONE;
        burst_cnt_d = '0;
        if (gnt[0]) begin
            prio_d = 1'b1;
            if (lock0 && !forced) begin
                owner_d     = OWN_R0;
                burst_cnt_d = (owner_q == OWN_R0) ? burst_inc(burst_cnt_q, MaxCnt)
                                                  : BURST_W'(1);
            end
        end else if (gnt[1]) begin
            prio_d = 1'b0;
            if (lock1 && !forced) begin
                owner_d     = OWN_R1;
                burst_cnt_d = (owner_q == OWN_R1) ? burst_inc(burst_cnt_q, MaxCnt)
                                                  : BURST_W'(1);
            end
        end
    end

    always_comb begin
        addr_d    = gnt[1] ? addr1 : (gnt[0] ? addr0 : addr_q);
        ram_wdata = gnt[1] ? wdata1 : wdata0;
        ram_we    = !rst && ((gnt[0] && we0) || (gnt[1] && we1));
        rvalid0_d = gnt[0] && !we0;
        rvalid1_d = gnt[1] && !we1;
        rdata0_d  = rvalid0_d ? ram_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? ram_rdata : rdata1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            owner_q     <= OWN_NONE;
            burst_cnt_q <= '0;
            addr_q      <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            addr_q      <= addr_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign gnt0    = gnt[0] && !rst;
    assign gnt1    = gnt[1] && !rst;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

    ram16x4 #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .addr_i (addr_d),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

endmodule

// File: doc/ram16x4_arbiter.md
Name: ram16x4_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port 16x4 RAM (synchronous write, asynchronous read) between two clients.
- Grants at most one access per clock and muxes the winner's address, data and write-enable onto the RAM.
- Returns registered read data one cycle after the grant.
- Supports optional locked bursts so one client can keep ownership for several consecutive accesses.

Parameters:
- ADDR_W, 4, RAM address width (16 locations).
- DATA_W, 4, RAM data width.
- MAX_BURST, 4, maximum consecutive grants to a locked owner while the other requester waits (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 access request; held until gnt0.
- we0  input  1  requester 0 write (1) / read (0).
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- lock0  input  1  requester 0 burst lock.
- gnt0  output  1  requester 0 access accepted this cycle.
- rvalid0  output  1  requester 0 read data valid.
- rdata0  output  DATA_W  requester 0 read data.
- req1, we1, addr1, wdata1, lock1, gnt1, rvalid1, rdata1: same as requester 0, for requester 1.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high.
  - During rst: gnt0/gnt1=0, RAM we=0, rvalid0/1=0, rdata0/1=0.
  - prio=0 (requester 0 favoured), owner=NONE, burst_cnt=0.
  - RAM contents are not cleared.
- Grant is combinational in the request cycle, from the registered state prio, owner and burst_cnt. gnt0 and gnt1 are never high together.
- Arbitration in each cycle:
  - If owner=k, reqk=1 and burst_cnt<MAX_BURST: grant k.
  - If owner=k, reqk=1, burst_cnt=MAX_BURST and the other requester is idle: grant k; burst_cnt saturates.
  - Otherwise, if only one requester is high: grant it.
  - If both are high: grant requester prio.
  - If neither is high: no grant; RAM we=0, RAM addr holds the last value.
- On grant to k, at the rising edge:
  - prio becomes not k.
  - If lockk=1: owner<=k; burst_cnt<=burst_cnt+1 if the owner was already k, else 1 (saturating at MAX_BURST).
  - If lockk=0: owner<=NONE, burst_cnt<=0.
- Forced release: when MAX_BURST is reached and the other requester is high, the other requester wins. owner<=NONE and burst_cnt<=0 at that edge, whatever lock is.
- Owner abandons: if owner=k and reqk=0, ownership is dropped that cycle (owner<=NONE, burst_cnt<=0). Normal round-robin applies.
- Writes: RAM we = granted wek. Data commits at the same edge. No response is returned for writes.
- Reads:
  - RAM read is asynchronous. The arbiter registers the granted RAM output into rdatak at the grant edge and pulses rvalidk high for exactly one cycle after it.
  - The other requester's rdata holds its previous value.
  - Read latency is 1 cycle; back-to-back reads give back-to-back rvalid pulses.
- Read-after-write, same address, consecutive cycles: the read returns the new data. Same-cycle write and read cannot occur because there is one port.
- Reset mid-burst or mid-read: the pending rvalid is dropped and owner is cleared. The write committed at the last edge before rst remains.
- Throughput is 1 access per cycle; there are no idle bubbles between grants.

Decomposition:
- Package ram_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - NUM_REQ=2.
  - Owner encoding: OWN_NONE=2'b00, OWN_R0=2'b01, OWN_R1=2'b10.
  - Burst counter width 4.
- Sub-module: instantiate the existing ram16x4 as u_ram. The arbiter contains only the grant logic, state registers, muxing and the response register.

Test Plan:
1. Reset then single writer: req0=1, we0=1, addr0=3, wdata0=4'hA for 1 cycle.
   - gnt0=1 same cycle, gnt1=0, no rvalid.
   - Then read addr0=3: gnt0=1 and, next cycle, rvalid0=1, rdata0=4'hA.
2. Contention round-robin: req0=req1=1 (reads, addr 0 and 1) held for 4 cycles, lock=0.
   - Grants alternate 0,1,0,1.
   - rvalid0/rvalid1 alternate one cycle later.
3. Locked burst with MAX_BURST=4: lock0=1, req0 continuous, req1=1 from the same cycle.
   - gnt0 for 4 cycles, then gnt1 on cycle 5.
   - owner cleared and burst_cnt=0 after cycle 5.
4. Read-after-write: cycle n writes addr 7 data 4'h5 from req1; cycle n+1 reads addr 7 from req0.
   - rvalid0=1 at n+2 with rdata0=4'h5.
5. Async reset mid-burst: assert rst between clock edges while owner=R0 and a read rvalid is pending.
   - gnt0/gnt1, rvalid0/1 and rdata0/1 go to 0 immediately.
   - After release, the first contention grants requester 0.
6. Idle and owner abandon: owner=R1 with lock1=1, req1 drops while req0=1.
   - gnt0 the same cycle; owner=NONE afterwards.
   - With no requests: RAM we=0 and no RAM contents change.
